dizy_round_ctrl: RTL and testbench

Round sequencer for iterative DIZY-80/128 encryption. Accepts one plaintext/key pair per valid/ready handshake and holds state and key in registers. Drives the round counter and key to the external combinational round datapath, which includes key extension and round function. Writes the returned state back once per round for NUM_RNDS cycles, then presents the ciphertext on a valid/ready output port. Sits between the core's I/O wrapper and the round logic.

---
 rtl/dizy_round_ctrl.sv | 128 ++++++++++++
 tb/tb_dizy_round_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dizy_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dizy_round_ctrl
// Function : Round sequencer for iterative DIZY-80/128; holds state/key and
//            steps an external combinational round datapath NUM_RNDS times.
// Revision : 1.0 - initial release
// ============================================================================
module dizy_round_ctrl #(
    parameter int SIZE_STATE = 120,
    parameter int SIZE_KEY   = 80,
    parameter int NUM_RNDS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE_STATE-1:0] in_data,
    input  logic [SIZE_KEY-1:0]   in_key,
    output logic [2:0]            rnd_cnt,
    output logic [SIZE_KEY-1:0]   rnd_key,
    output logic [SIZE_STATE-1:0] rnd_state,
    input  logic [SIZE_STATE-1:0] rnd_state_nxt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE_STATE-1:0] out_data,
    input  logic                  abort,
    output logic                  busy
);

    generate
        if ((NUM_RNDS < 1) || (NUM_RNDS > 8)) begin : g_bad_num_rnds
            $error("dizy_round_ctrl: NUM_RNDS must be in 1..8");
        end
    endgenerate

    localparam logic [2:0] c_last_cnt = 3'(NUM_RNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    fsm_e                  fsm_q,   fsm_d;
    logic [SIZE_STATE-1:0] state_q, state_d;
    logic [SIZE_KEY-1:0]   key_q,   key_d;
    logic [2:0]            cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            cnt_q   <= 3'd0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        key_d     = key_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data;
                    key_d   = in_key;
                    cnt_d   = 3'd0;
                    fsm_d   = ST_RUN;
                end
            end

            ST_RUN: begin
                busy = 1'b1;
                // Abort freezes state/key where they are so the datapath view stays coherent.
                if (abort) begin
                    cnt_d = 3'd0;
                    fsm_d = ST_IDLE;
                end else begin
                    state_d = rnd_state_nxt;
                    if (cnt_q == c_last_cnt) begin
                        cnt_d = 3'd0;
                        fsm_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = in_data;
                        key_d   = in_key;
                        cnt_d   = 3'd0;
                        fsm_d   = ST_RUN;
                    end else begin
                        fsm_d = ST_IDLE;
                    end
                end
            end

            default: begin
                fsm_d = ST_IDLE;
                cnt_d = 3'd0;
            end
        endcase
    end

    assign rnd_state = state_q;
    assign out_data  = state_q;
    assign rnd_key   = key_q;
    assign rnd_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dizy_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dizy_round_ctrl
// Function : Self-checking bench for dizy_round_ctrl (NUM_RNDS=8 and =1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dizy_round_ctrl;

    localparam int SS = 120;
    localparam int SK = 80;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          stub_mode;
    logic          in_valid[2], in_ready[2], out_valid[2], out_ready[2], abort[2], busy[2];
    logic [SS-1:0] in_data[2], rnd_state[2], rnd_state_nxt[2], out_data[2];
    logic [SK-1:0] in_key[2], rnd_key[2];
    logic [2:0]    rnd_cnt[2];

    int checks   = 0;
    int failures = 0;

    function automatic int nr(input int d);
        return (d == 0) ? 8 : 1;
    endfunction

    // Toy round function: depends on state, key and round index.
    function automatic logic [SS-1:0] rf(input logic [SS-1:0] s, input logic [SK-1:0] k,
                                         input logic [2:0] r);
        return (({s[SS-2:0], s[SS-1]} ^ {40'd0, k}) + {117'd0, r} + 120'd1);
    endfunction

    function automatic logic [SS-1:0] cipher(input logic [SS-1:0] p, input logic [SK-1:0] k,
                                             input int n);
        logic [SS-1:0] s;
        s = p;
        for (int r = 0; r < n; r++) s = rf(s, k, 3'(r));
        return s;
    endfunction

    generate
        for (genvar d = 0; d < 2; d++) begin : g_stub
            assign rnd_state_nxt[d] = stub_mode ? rf(rnd_state[d], rnd_key[d], rnd_cnt[d])
                                                : rnd_state[d] + 120'd1;
        end
    endgenerate

    dizy_round_ctrl #(.SIZE_STATE(SS), .SIZE_KEY(SK), .NUM_RNDS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_key(in_key[0]),
        .rnd_cnt(rnd_cnt[0]), .rnd_key(rnd_key[0]),
        .rnd_state(rnd_state[0]), .rnd_state_nxt(rnd_state_nxt[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .abort(abort[0]), .busy(busy[0])
    );

    dizy_round_ctrl #(.SIZE_STATE(SS), .SIZE_KEY(SK), .NUM_RNDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_key(in_key[1]),
        .rnd_cnt(rnd_cnt[1]), .rnd_key(rnd_key[1]),
        .rnd_state(rnd_state[1]), .rnd_state_nxt(rnd_state_nxt[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .abort(abort[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [SS-1:0] got, input logic [SS-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Transaction-level model state for the random phase.
    logic          m_have[2];
    int            m_left[2];
    logic [SS-1:0] m_ct[2];
    logic [SK-1:0] m_key[2];

    initial begin
        logic ov_seen;
        logic e_ov, e_ir, e_busy, acc;

        stub_mode = 1'b0;
        rst_n     = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            abort[d]     = 1'b0;
            in_data[d]   = '0;
            in_key[d]    = '0;
            m_have[d]    = 1'b0;
            m_left[d]    = 0;
            m_ct[d]      = '0;
            m_key[d]     = '0;
        end

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready",  in_ready[d],  1);
            check("rst_out_valid", out_valid[d], 0);
            check("rst_busy",      busy[d],      0);
            check("rst_rnd_cnt",   rnd_cnt[d],   0);
            check("rst_rnd_state", rnd_state[d], 0);
            check("rst_rnd_key",   rnd_key[d],   0);
        end

        // Single block, 8 rounds
        in_valid[0] = 1'b1; in_data[0] = 120'h5; in_key[0] = 80'hA5; out_ready[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            check("blk_rnd_cnt",   rnd_cnt[0],   120'(r));
            check("blk_rnd_key",   rnd_key[0],   120'hA5);
            check("blk_rnd_state", rnd_state[0], 120'(5 + r));
            check("blk_busy",      busy[0],      1);
            check("blk_out_valid", out_valid[0], 0);
            tick();
        end
        check("blk_done_valid", out_valid[0], 1);
        check("blk_done_data",  out_data[0],  120'hD);
        check("blk_done_busy",  busy[0],      0);

        // Backpressure in DONE with a pending input
        out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 120'h20; in_key[0] = 80'h3C;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data",     out_data[0],  120'hD);
            check("bp_in_ready", in_ready[0],  0);
            check("bp_valid",    out_valid[0], 1);
        end
        out_ready[0] = 1'b1;
        #1;
        check("bp_in_ready_rel", in_ready[0], 1);
        tick();
        in_valid[0] = 1'b0;
        check("bp_load_state", rnd_state[0], 120'h20);
        check("bp_load_key",   rnd_key[0],   120'h3C);
        check("bp_load_busy",  busy[0],      1);
        check("bp_load_ov",    out_valid[0], 0);
        repeat (8) tick();
        check("bp2_valid", out_valid[0], 1);
        check("bp2_data",  out_data[0],  120'h28);
        tick();
        check("bp2_idle_ov", out_valid[0], 0);
        check("bp2_idle_ir", in_ready[0],  1);

        // Abort at rnd_cnt=3, with a competing input
        in_valid[0] = 1'b1; in_data[0] = 120'h40; in_key[0] = 80'h11;
        tick();
        in_valid[0] = 1'b0;
        repeat (3) tick();
        check("ab_cnt3", rnd_cnt[0], 3);
        abort[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 120'h99;
        #1;
        check("ab_in_ready", in_ready[0], 0);
        tick();
        abort[0] = 1'b0; in_valid[0] = 1'b0;
        check("ab_busy",  busy[0],      0);
        check("ab_cnt",   rnd_cnt[0],   0);
        check("ab_state", rnd_state[0], 120'h43);
        check("ab_key",   rnd_key[0],   120'h11);
        check("ab_ir",    in_ready[0],  1);
        ov_seen = 1'b0;
        repeat (10) begin
            tick();
            if (out_valid[0]) ov_seen = 1'b1;
        end
        check("ab_no_ov", ov_seen, 0);
        in_valid[0] = 1'b1; in_data[0] = 120'h0;
        tick();
        in_valid[0] = 1'b0;
        repeat (8) tick();
        check("ab_next_valid", out_valid[0], 1);
        check("ab_next_data",  out_data[0],  120'h8);

        // Abort in DONE is ignored
        out_ready[0] = 1'b0; abort[0] = 1'b1;
        repeat (2) begin
            tick();
            check("abd_valid", out_valid[0], 1);
            check("abd_data",  out_data[0],  120'h8);
            check("abd_busy",  busy[0],      0);
        end
        abort[0] = 1'b0; out_ready[0] = 1'b1;
        tick();
        check("abd_release", out_valid[0], 0);

        // NUM_RNDS=1 build
        in_valid[1] = 1'b1; in_data[1] = 120'h7; in_key[1] = 80'h5;
        tick();
        in_valid[1] = 1'b0;
        check("n1_busy",  busy[1],      1);
        check("n1_cnt0",  rnd_cnt[1],   0);
        check("n1_ov0",   out_valid[1], 0);
        tick();
        check("n1_valid", out_valid[1], 1);
        check("n1_data",  out_data[1],  120'h8);
        check("n1_cnt1",  rnd_cnt[1],   0);
        tick();
        check("n1_idle",  out_valid[1], 0);

        // Randomized streaming against the transaction model
        stub_mode = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 3) != 0);
                out_ready[d] = ($urandom_range(0, 3) != 0);
                in_data[d]   = SS'({$urandom(), $urandom(), $urandom(), $urandom()});
                in_key[d]    = SK'({$urandom(), $urandom(), $urandom()});
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                e_ov   = m_have[d] && (m_left[d] == 0);
                e_ir   = !m_have[d] || ((m_left[d] == 0) && out_ready[d]);
                e_busy = m_have[d] && (m_left[d] > 0);
                check("rnd_ov",   out_valid[d], e_ov);
                check("rnd_ir",   in_ready[d],  e_ir);
                check("rnd_busy", busy[d],      e_busy);
                if (e_busy) begin
                    check("rnd_cnt", rnd_cnt[d], 120'(nr(d) - m_left[d]));
                    check("rnd_key", rnd_key[d], m_key[d]);
                end
                if (e_ov) check("rnd_ct", out_data[d], m_ct[d]);
                acc = e_ir && in_valid[d];
                if (m_have[d] && (m_left[d] > 0)) m_left[d]--;
                else if (m_have[d] && out_ready[d]) m_have[d] = 1'b0;
                if (acc) begin
                    m_have[d] = 1'b1;
                    m_left[d] = nr(d);
                    m_ct[d]   = cipher(in_data[d], in_key[d], nr(d));
                    m_key[d]  = in_key[d];
                end
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
